// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// memory-stall freeze and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_branch,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_branch,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              load_use,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int unsigned OP_W = 4;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              reg_dst;
        logic              branch;
        logic [OP_W-1:0]   alu_op;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
    } idex_t;

    idex_t            id_s;
    idex_t            ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        id_s = '{rs: id_rs, rt: id_rt, rd: id_rd,
                 reg_write: id_reg_write, mem_read: id_mem_read,
                 mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                 alu_src: id_alu_src, reg_dst: id_reg_dst, branch: id_branch,
                 alu_op: id_alu_op, rdata1: id_rdata1, rdata2: id_rdata2,
                 imm: id_imm};
    end

    // A zero rt never stalls: $0 cannot carry a pending load result.
    assign load_use = ex_q.mem_read && (ex_q.rt != '0) &&
                      ((ex_q.rt == id_rs) || (id_uses_rt && (ex_q.rt == id_rt)));

    // Update priority: stall > flush > load-use bubble > normal advance.
    always_comb begin
        ex_d       = ex_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (flush) begin
            ex_d = '0;
        end else if (load_use) begin
            ex_d       = '0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d = id_s;
        end
        // Front end is released while reset holds the pipeline empty.
        if (!reset_n) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_dst    = ex_q.reg_dst;
    assign ex_branch     = ex_q.branch;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_rdata1     = ex_q.rdata1;
    assign ex_rdata2     = ex_q.rdata2;
    assign ex_imm        = ex_q.imm;
    assign ex_write_reg  = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
    assign bubble_count  = cnt_q;

endmodule
